vertex_loader: RTL and testbench



---
 rtl/vertex_loader_pkg.sv | 19 +
 rtl/vertex_loader.sv | 149 ++++++++++++++
 tb/tb_vertex_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_loader_pkg.sv
// rtl/vertex_loader_pkg.sv - shared graph constants, vertex type and loader state encoding
package vertex_loader_pkg;

  // One host cacheline carries eight 64-bit vertex slots
  localparam int CL_W         = 512;
  localparam int VERTEX_W     = 64;
  localparam int VERTS_PER_CL = 8;
  localparam int VERT_IDX_W   = 3;

  typedef logic [VERTEX_W-1:0] vertex_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } ld_state_t;

endpackage

// File: rtl/vertex_loader.sv
// rtl/vertex_loader.sv - streams host cachelines into the vertex RAM by request tag
module vertex_loader
  import vertex_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int CL_ADDR_W = 42
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]      num_vertices,
  output logic                 rd_req_valid,
  output logic [CL_ADDR_W-1:0] rd_req_addr,
  output logic [ADDR_W-4:0]    rd_req_tag,
  input  logic                 rd_req_almfull,
  input  logic                 rd_rsp_valid,
  input  logic [ADDR_W-4:0]    rd_rsp_tag,
  input  logic [CL_W-1:0]      rd_rsp_data,
  output logic [CL_W-1:0]      cl_out,
  output logic [ADDR_W-1:0]    w_addr,
  output logic                 we_out,
  output logic                 busy,
  output logic                 done
);

  localparam int TAG_W = ADDR_W - 3;
  // One extra bit so a completely full RAM's line count does not wrap
  localparam int CNT_W = ADDR_W - 2;

  ld_state_t state, next_state;

  logic [CL_ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]     n_lines_q;
  logic [CNT_W-1:0]     req_cnt;
  logic [CNT_W-1:0]     rsp_cnt;

  logic [ADDR_W:0]      num_sat;
  logic [CNT_W-1:0]     n_lines_start;
  logic                 start_load;
  logic                 issue;
  logic                 rsp_accept;

  // Saturate the vertex count to the RAM size and round up to whole cachelines
  always_comb begin
    num_sat = num_vertices;
    if (num_vertices[ADDR_W]) begin
      num_sat = {1'b1, {ADDR_W{1'b0}}};
    end
    n_lines_start = CNT_W'((num_sat + (ADDR_W+1)'(VERTS_PER_CL - 1)) >> VERT_IDX_W);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus status strobes; responses only count while busy
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    start_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (n_lines_start != '0) begin
            start_load = 1'b1;
            next_state = S_REQ;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_REQ: begin
        busy = 1'b1;
        if (!rd_req_almfull) begin
          issue = 1'b1;
          if (req_cnt == n_lines_q - CNT_W'(1)) begin
            next_state = (rsp_cnt == n_lines_q) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (rsp_cnt == n_lines_q) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    rsp_accept = rd_rsp_valid & busy;
  end

  // Load parameters, request counter and the registered read-request port
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q       <= '0;
      n_lines_q    <= '0;
      req_cnt      <= '0;
      rsp_cnt      <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_tag   <= '0;
    end else begin
      rd_req_valid <= issue;
      if (start_load) begin
        base_q    <= base_addr;
        n_lines_q <= n_lines_start;
        req_cnt   <= '0;
        rsp_cnt   <= '0;
      end else begin
        if (issue) begin
          rd_req_addr <= base_q + CL_ADDR_W'(req_cnt);
          rd_req_tag  <= req_cnt[TAG_W-1:0];
          req_cnt     <= req_cnt + CNT_W'(1);
        end
        if (rsp_accept) begin
          rsp_cnt <= rsp_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Each accepted response becomes one cacheline write addressed purely by its tag
  always_ff @(posedge clk) begin
    if (reset) begin
      we_out <= 1'b0;
      w_addr <= '0;
      cl_out <= '0;
    end else begin
      we_out <= rsp_accept;
      if (rsp_accept) begin
        w_addr <= {rd_rsp_tag, {VERT_IDX_W{1'b0}}};
        cl_out <= rd_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_vertex_loader.sv
// tb/tb_vertex_loader.sv - directed self-checking bench for vertex_loader
module tb_vertex_loader;
  import vertex_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int CL_ADDR_W = 42;
  localparam int TAG_W     = ADDR_W - 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [CL_ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]      num_vertices = '0;
  logic                 rd_req_valid;
  logic [CL_ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]     rd_req_tag;
  logic                 rd_req_almfull = 1'b0;
  logic                 rd_rsp_valid = 1'b0;
  logic [TAG_W-1:0]     rd_rsp_tag = '0;
  logic [CL_W-1:0]      rd_rsp_data = '0;
  logic [CL_W-1:0]      cl_out;
  logic [ADDR_W-1:0]    w_addr;
  logic                 we_out;
  logic                 busy;
  logic                 done;

  vertex_loader #(.ADDR_W(ADDR_W), .CL_ADDR_W(CL_ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_vertices  (num_vertices),
    .rd_req_valid  (rd_req_valid),
    .rd_req_addr   (rd_req_addr),
    .rd_req_tag    (rd_req_tag),
    .rd_req_almfull(rd_req_almfull),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_tag    (rd_rsp_tag),
    .rd_rsp_data   (rd_rsp_data),
    .cl_out        (cl_out),
    .w_addr        (w_addr),
    .we_out        (we_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int req_count  = 0;
  int we_count   = 0;
  int done_count = 0;
  int seq_err    = 0;
  int wr_err     = 0;
  int load_req   = 0;
  logic [CL_ADDR_W-1:0] exp_base = '0;

  int r0, w0, d0;

  function automatic logic [CL_W-1:0] mkdata(input logic [TAG_W-1:0] t);
    return {16{24'hC0FFEE, 3'b000, t}};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_cl(input string name, input logic [CL_W-1:0] obs, input logic [CL_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one response for a cycle and check the write it should (or should not) cause
  task automatic respond(input int t, input bit exp_we);
    rd_rsp_valid = 1'b1;
    rd_rsp_tag   = TAG_W'(t);
    rd_rsp_data  = mkdata(TAG_W'(t));
    tick();
    rd_rsp_valid = 1'b0;
    chk("rsp_we_out", 64'(we_out), 64'(exp_we));
    if (exp_we) begin
      chk("rsp_w_addr", 64'(w_addr), 64'(t * 8));
      chk_cl("rsp_cl_out", cl_out, mkdata(TAG_W'(t)));
    end
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  // Passive observer: request ordering/addressing and write payload consistency
  always @(negedge clk) begin
    if (rd_req_valid) req_count++;
    if (we_out) begin
      we_count++;
      if (cl_out !== mkdata(w_addr[ADDR_W-1:3]) || w_addr[2:0] !== 3'b000) wr_err++;
    end
    if (done) done_count++;
    if (!busy) begin
      load_req = 0;
    end else if (rd_req_valid) begin
      if (rd_req_tag !== TAG_W'(load_req) || rd_req_addr !== exp_base + CL_ADDR_W'(load_req)) seq_err++;
      load_req++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_req_addr", 64'(rd_req_addr), 64'd0);
    chk("rst_req_tag", 64'(rd_req_tag), 64'd0);
    chk("rst_we_out", 64'(we_out), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    chk_cl("rst_cl_out", cl_out, '0);
    reset = 1'b0;
    tick();

    // 20 vertices -> 3 lines, responses out of order 2,0,1
    d0 = done_count;
    exp_base = 42'h1000;
    base_addr = 42'h1000;
    num_vertices = 9'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy_after_start", 64'(busy), 64'd1);
    chk("a_no_req_yet", 64'(rd_req_valid), 64'd0);
    tick();
    chk("a_req0_valid", 64'(rd_req_valid), 64'd1);
    chk("a_req0_addr", 64'(rd_req_addr), 64'h1000);
    chk("a_req0_tag", 64'(rd_req_tag), 64'd0);
    tick();
    chk("a_req1_addr", 64'(rd_req_addr), 64'h1001);
    chk("a_req1_tag", 64'(rd_req_tag), 64'd1);
    tick();
    chk("a_req2_valid", 64'(rd_req_valid), 64'd1);
    chk("a_req2_addr", 64'(rd_req_addr), 64'h1002);
    chk("a_req2_tag", 64'(rd_req_tag), 64'd2);
    tick();
    chk("a_req_stop", 64'(rd_req_valid), 64'd0);
    respond(2, 1'b1);
    respond(0, 1'b1);
    respond(1, 1'b1);
    chk("a_done_not_early", 64'(done), 64'd0);
    chk("a_busy_before_done", 64'(busy), 64'd1);
    tick();
    chk("a_done_pulse", 64'(done), 64'd1);
    chk("a_busy_low_at_done", 64'(busy), 64'd0);
    tick();
    chk("a_done_one_cycle", 64'(done), 64'd0);
    chk("a_done_count", 64'(done_count - d0), 64'd1);
    chk("a_req_count", 64'(req_count), 64'd3);

    // Same load with almfull held for 3 cycles after the first request
    r0 = req_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("b_req0_tag", 64'(rd_req_tag), 64'd0);
    rd_req_almfull = 1'b1;
    tick();
    chk("b_stall1", 64'(rd_req_valid), 64'd0);
    tick();
    tick();
    chk("b_stall3", 64'(rd_req_valid), 64'd0);
    rd_req_almfull = 1'b0;
    tick();
    chk("b_req1_addr", 64'(rd_req_addr), 64'h1001);
    tick();
    tick();
    respond(1, 1'b1);
    respond(2, 1'b1);
    respond(0, 1'b1);
    wait_done(5, "b_done");
    tick();
    chk("b_req_count", 64'(req_count - r0), 64'd3);

    // Zero vertices: immediate done, nothing issued or written
    r0 = req_count;
    w0 = we_count;
    num_vertices = 9'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_done", 64'(done), 64'd1);
    chk("c_busy", 64'(busy), 64'd0);
    tick();
    chk("c_done_cleared", 64'(done), 64'd0);
    tick();
    chk("c_no_req", 64'(req_count - r0), 64'd0);
    chk("c_no_we", 64'(we_count - w0), 64'd0);

    // 300 vertices saturate to 256 -> 32 lines; base chosen so addresses wrap
    r0 = req_count;
    exp_base = 42'h3FF_FFFF_FFF0;
    base_addr = 42'h3FF_FFFF_FFF0;
    num_vertices = 9'd300;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    chk("d_last_req_wrapped", 64'(rd_req_addr), 64'h0F);
    tick();
    chk("d_req_count", 64'(req_count - r0), 64'd32);
    for (int t = 30; t >= 0; t--) respond(t, 1'b1);
    chk("d_busy_after_31", 64'(busy), 64'd1);
    respond(31, 1'b1);
    chk("d_last_w_addr", 64'(w_addr), 64'd248);
    tick();
    chk("d_done", 64'(done), 64'd1);
    chk("d_busy_dropped", 64'(busy), 64'd0);
    tick();

    // Response while idle is dropped; start while busy is ignored
    w0 = we_count;
    respond(5, 1'b0);
    chk("e_idle_rsp_dropped", 64'(we_count - w0), 64'd0);
    r0 = req_count;
    exp_base = 42'h500;
    base_addr = 42'h500;
    num_vertices = 9'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    base_addr = 42'h900;
    num_vertices = 9'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("e_req_count", 64'(req_count - r0), 64'd1);
    chk("e_still_busy", 64'(busy), 64'd1);
    respond(0, 1'b1);
    wait_done(5, "e_done");
    tick();
    chk("e_we_count", 64'(we_count - w0), 64'd1);

    // Reset after 2 of 4 responses, stragglers dropped, then a fresh load
    exp_base = 42'h2000;
    base_addr = 42'h2000;
    num_vertices = 9'd32;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    respond(3, 1'b1);
    respond(1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("f_busy_after_reset", 64'(busy), 64'd0);
    chk("f_req_valid_after_reset", 64'(rd_req_valid), 64'd0);
    w0 = we_count;
    d0 = done_count;
    respond(0, 1'b0);
    respond(2, 1'b0);
    chk("f_stale_no_we", 64'(we_count - w0), 64'd0);
    chk("f_no_done", 64'(done_count - d0), 64'd0);
    exp_base = 42'h4000;
    base_addr = 42'h4000;
    num_vertices = 9'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("f_fresh_req_addr", 64'(rd_req_addr), 64'h4000);
    tick();
    respond(0, 1'b1);
    wait_done(5, "f_fresh_done");
    tick();

    chk("seq_errors", 64'(seq_err), 64'd0);
    chk("write_errors", 64'(wr_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
